// File: rtl/seq_karatsuba_divider.sv
// seq_karatsuba_divider: iterative restoring divider, 2W-bit dividend by a
// W-bit divisor, one quotient bit per clock. Unpacks Karatsuba products back
// into their co-factor and checks the multiplier datapath by round trip.
module seq_karatsuba_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  // Partial remainder is always below the divisor, so its (W+1)-th bit is
  // implicitly zero and only W bits are stored; the trial value carries W+1.
  logic [WIDTH-1:0]   r_rem;
  // Low dividend half shifts out of the MSB while quotient bits shift into
  // the LSB, so after W steps this register holds the whole quotient.
  logic [WIDTH-1:0]   r_low;
  logic [WIDTH-1:0]   r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_div_by_zero;
  logic               r_overflow;

  logic               w_accept;
  logic               w_div_zero;
  logic               w_quo_ovf;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;

  assign w_accept   = start && (r_state != S_RUN);
  assign w_div_zero = (divisor == '0);
  assign w_quo_ovf  = !w_div_zero && (dividend[2*WIDTH-1:WIDTH] >= divisor);

  // Trial subtraction. Because R < divisor, T = 2R + bit < 2*divisor, so a
  // non-negative difference always fits in W bits and the MSB of the
  // (W+1)-bit difference is exactly the borrow.
  assign w_trial    = {r_rem, r_low[WIDTH-1]};
  assign w_diff     = w_trial - {1'b0, r_div};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and status outputs.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          w_next_state = (w_div_zero || w_quo_ovf) ? S_DONE : S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == '0) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture, one restoring step per RUN edge, and result update on
  // entry to DONE. Results hold at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem         <= '0;
      r_low         <= '0;
      r_div         <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (w_accept) begin
      r_rem         <= dividend[2*WIDTH-1:WIDTH];
      r_low         <= dividend[WIDTH-1:0];
      r_div         <= divisor;
      r_cnt         <= CNT_W'(WIDTH - 1);
      r_div_by_zero <= w_div_zero;
      r_overflow    <= w_quo_ovf;
      if (w_div_zero || w_quo_ovf) begin
        r_quotient  <= '1;
        r_remainder <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem_next;
      r_low <= {r_low[WIDTH-2:0], w_qbit};
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_quotient  <= {r_low[WIDTH-2:0], w_qbit};
        r_remainder <= w_rem_next;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule
